// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO of {pc, inst} with flush.
// Optional macro FETCH_QUEUE_NOP_BUBBLE_EN presents a NOP on out_inst while the queue is empty.
module fetch_decode_queue #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_inst,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_inst,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];

    // Ready and valid come only from the occupancy register: no pass-through, no bypass.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is never reset or cleared; pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
        end
    end

    always_comb begin
        out_pc   = '0;
        out_inst = '0;
        if (out_valid) begin
            out_pc   = pc_mem[rd_ptr];
            out_inst = inst_mem[rd_ptr];
        end else begin
`ifdef FETCH_QUEUE_NOP_BUBBLE_EN
            // Bubble as addi x0,x0,0, but keep zero while reset is held.
            if (reset_n) out_inst = NOP_INST;
`else
            out_inst = '0;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomized bench for fetch_decode_queue against a queue-based reference model,
// plus directed cases for latency, full, wrap, flush and asynchronous reset.
module tb_fetch_decode_queue;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef FETCH_QUEUE_NOP_BUBBLE_EN
    localparam logic [31:0] BUBBLE = 32'h0000_0013;
`else
    localparam logic [31:0] BUBBLE = 32'h0000_0000;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_inst;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_inst;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;
    ent_t mq[$];

    fetch_decode_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare all DUT outputs against the model's current contents.
    task automatic check_outputs(input string tag);
        int n;
        n = mq.size();
        check_eq({tag, ".count"},     32'(count),     32'(n));
        check_eq({tag, ".in_ready"},  32'(in_ready),  32'(n != DEPTH));
        check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
        if (n != 0) begin
            check_eq({tag, ".out_pc"},   out_pc,   mq[0].pc);
            check_eq({tag, ".out_inst"}, out_inst, mq[0].inst);
        end else begin
            check_eq({tag, ".out_pc"},   out_pc,   32'h0);
            check_eq({tag, ".out_inst"}, out_inst, BUBBLE);
        end
    endtask

    // One cycle: called just after a falling edge, returns after the next falling edge.
    task automatic step(input string tag, input logic iv, input logic [31:0] pc,
                        input logic [31:0] inst, input logic fl, input logic ordy);
        logic do_push, do_pop;
        ent_t e;
        in_valid  = iv;
        in_pc     = pc;
        in_inst   = inst;
        flush     = fl;
        out_ready = ordy;
        #1;
        check_outputs(tag);
        do_push = iv && (mq.size() != DEPTH) && !fl;
        do_pop  = (mq.size() != 0) && ordy && !fl;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.pc   = pc;
                e.inst = inst;
                mq.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        check_eq("rst.out_valid", 32'(out_valid), 32'h0);
        check_eq("rst.in_ready",  32'(in_ready),  32'h1);
        check_eq("rst.count",     32'(count),     32'h0);
        check_eq("rst.out_pc",    out_pc,         32'h0);
        check_eq("rst.out_inst",  out_inst,       32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // First push becomes visible one cycle later.
        step("lat0", 1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
        step("lat1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_eq("lat.out_inst", out_inst, 32'h0050_0093);

        // Fill to full; extra word must be refused, then drain in order.
        step("full0", 1'b1, 32'h4, 32'h1111_0001, 1'b0, 1'b0);
        step("full1", 1'b1, 32'h8, 32'h1111_0002, 1'b0, 1'b0);
        step("full2", 1'b1, 32'hC, 32'h1111_0003, 1'b0, 1'b1);
        step("full3", 1'b1, 32'h10, 32'h1111_0004, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step("drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Steady push+pop at occupancy 1 walks the pointers around several times.
        step("pp_fill", 1'b1, 32'h100, 32'hA000_0000, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++)
            step("pp", 1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b1);
        check_eq("pp.count", 32'(count), 32'h1);
        step("pp_drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Flush with a competing push: the flushed word must never appear.
        step("fl0", 1'b1, 32'h200, 32'hB000_0001, 1'b0, 1'b0);
        step("fl1", 1'b1, 32'h204, 32'hB000_0002, 1'b0, 1'b0);
        step("fl2", 1'b1, 32'h208, 32'hDEAD_BEEF, 1'b1, 1'b1);
        check_eq("fl.count", 32'(count), 32'h0);
        check_eq("fl.out_valid", 32'(out_valid), 32'h0);
        step("fl3", 1'b1, 32'h300, 32'hC000_0001, 1'b0, 1'b0);
        step("fl4", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step("fl5", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Asynchronous reset between edges with the queue full and handshakes pending.
        step("ar0", 1'b1, 32'h400, 32'hD000_0001, 1'b0, 1'b0);
        step("ar1", 1'b1, 32'h404, 32'hD000_0002, 1'b0, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst.out_valid", 32'(out_valid), 32'h0);
        check_eq("arst.in_ready",  32'(in_ready),  32'h1);
        check_eq("arst.count",     32'(count),     32'h0);
        check_eq("arst.out_pc",    out_pc,         32'h0);
        check_eq("arst.out_inst",  out_inst,       32'h0);
        mq.delete();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        step("post_rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step("rnd", 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
